mux8_rr_sched: RTL and testbench

Round-robin scheduler that shares one `mux8` data path among eight single-bit requesters. It arbitrates the `req` lines and holds each grant for a bounded burst. It drives the `mux8` select lines from a registered owner index and flags when the muxed output `o` carries the granted requester's data. It sits between the requester blocks and the shared `mux8` instance, which it contains.

---
 rtl/mux8_rr_sched_pkg.sv | 20 ++
 rtl/mux8.sv | 12 +
 rtl/rr_pick8.sv | 28 ++
 rtl/mux8_rr_sched.sv | 105 ++++++++++
 tb/tb_mux8_rr_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux8 scheduler.
package mux8_rr_sched_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    function automatic logic [0:N_REQ-1] onehot(input logic [IDX_W-1:0] idx);
        logic [0:N_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8.sv
// Eight-to-one single-bit multiplexer; select index is j0*4 + j1*2 + j2.
module mux8 (
    input  logic [0:7] i,
    input  logic       j2,
    input  logic       j1,
    input  logic       j0,
    output logic       o
);

    assign o = i[{j0, j1, j2}];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set, non-excluded req bit searching from ptr upward (mod 8).
module rr_pick8
    import mux8_rr_sched_pkg::*;
(
    input  logic [0:N_REQ-1]   req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [0:N_REQ-1]   excl,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the candidate closest to ptr is written last and wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand] && !excl[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one mux8 among eight requesters, with bounded bursts per grant.
module mux8_rr_sched
    import mux8_rr_sched_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [0:7]   req,
    input  logic [0:7]   i,
    output logic [0:7]   gnt,
    output logic         j2,
    output logic         j1,
    output logic         j0,
    output logic         o,
    output logic         valid
);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST);

    sched_state_t       state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_ptr;
    logic [0:N_REQ-1]   pick_excl;
    logic               others;
    logic               release_now;

    // While busy, the picker searches from the pointer the release is about to install.
    always_comb begin
        pick_ptr    = ptr;
        pick_excl   = '0;
        others      = |(req & ~onehot(owner));
        release_now = 1'b0;
        if (state == BUSY) begin
            pick_ptr    = owner + 3'd1;
            pick_excl   = onehot(owner);
            release_now = !req[owner] || ((cnt == BURST_CNT) && others);
        end
    end

    rr_pick8 u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .excl (pick_excl),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        gnt   <= onehot(pick_idx);
                        valid <= 1'b1;
                        cnt   <= CNT_W'(1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= owner + 3'd1;
                        if (pick_any) begin
                            owner <= pick_idx;
                            gnt   <= onehot(pick_idx);
                            cnt   <= CNT_W'(1);
                        end else begin
                            gnt   <= '0;
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (cnt != BURST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Selects come straight off the owner flops, so they hold their value while idle.
    assign {j0, j1, j2} = owner;

    mux8 u_mux8 (
        .i  (i),
        .j2 (j2),
        .j1 (j1),
        .j0 (j0),
        .o  (o)
    );

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed and randomized bench for mux8_rr_sched against a queue-free behavioural arbitration model.
module tb_mux8_rr_sched;

    localparam int BURST = 4;

    logic       clk;
    logic       reset_n;
    logic [0:7] req;
    logic [0:7] i;
    logic [0:7] gnt;
    logic       j2, j1, j0;
    logic       o;
    logic       valid;

    int checkCount;
    int passCount;

    // Reference model: owner is -1 when nobody holds the mux.
    int mOwner;
    int mPtr;
    int mCnt;
    int mSel;

    mux8_rr_sched #(.BURST(BURST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .i       (i),
        .gnt     (gnt),
        .j2      (j2),
        .j1      (j1),
        .j0      (j0),
        .o       (o),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pickFrom(input logic [0:7] r, input int start, input int skip);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (r[idx] && idx != skip) return idx;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mOwner = -1;
        mPtr   = 0;
        mCnt   = 0;
        mSel   = 0;
    endtask

    task automatic modelStep(input logic [0:7] r);
        int  w;
        bit  othersWaiting;
        if (mOwner < 0) begin
            w = pickFrom(r, mPtr, -1);
            if (w >= 0) begin
                mOwner = w;
                mSel   = w;
                mCnt   = 1;
            end
        end else begin
            othersWaiting = (pickFrom(r, 0, mOwner) >= 0);
            if (!r[mOwner] || (mCnt == BURST && othersWaiting)) begin
                mPtr = (mOwner + 1) % 8;
                w    = pickFrom(r, mPtr, mOwner);
                if (w >= 0) begin
                    mOwner = w;
                    mSel   = w;
                    mCnt   = 1;
                end else begin
                    mOwner = -1;
                end
            end else if (mCnt < BURST) begin
                mCnt = mCnt + 1;
            end
        end
    endtask

    task automatic checkBits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [0:7] expGnt;
        logic [2:0] sel;
        expGnt = '0;
        if (mOwner >= 0) expGnt[mOwner] = 1'b1;
        sel = mSel[2:0];
        checkBits({tag, ".gnt"},   gnt,               expGnt);
        checkBits({tag, ".valid"}, {7'b0, valid},     {7'b0, (mOwner >= 0)});
        checkBits({tag, ".sel"},   {5'b0, j0, j1, j2}, {5'b0, sel});
        checkBits({tag, ".o"},     {7'b0, o},         {7'b0, i[mSel]});
    endtask

    // Drive between edges, let the DUT and model step on the edge, compare on the falling edge.
    task automatic applyStimulus(input logic [0:7] r, input logic [0:7] d, input string tag);
        req = r;
        i   = d;
        @(posedge clk);
        modelStep(r);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        logic [0:7] rr;
        logic [0:7] ri;
        checkCount = 0;
        passCount  = 0;
        reset_n    = 1'b0;
        req        = '0;
        i          = '0;
        modelReset();

        #3;
        checkOutput("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Two requesters: 2 wins first, holds BURST cycles, then 5 takes over without a gap.
        for (int c = 0; c < 2 * BURST; c++)
            applyStimulus(8'b0010_0100, 8'b0010_0000, "burst25");
        checkBits("burst25.final_gnt", gnt, 8'b0000_0100);
        checkBits("burst25.final_sel", {5'b0, j0, j1, j2}, 8'b0000_0101);

        applyStimulus(8'b0000_0000, 8'b0000_0100, "drop25");
        applyStimulus(8'b0000_0000, 8'b1111_1011, "idle25");

        // Lone requester keeps the grant; a newcomer then forces rotation on the next edge.
        for (int c = 0; c < 20; c++)
            applyStimulus(8'b0000_0001, 8'($urandom), "solo7");
        applyStimulus(8'b1000_0001, 8'b1000_0000, "rot70");
        checkBits("rot70.gnt", gnt, 8'b1000_0000);
        applyStimulus(8'b0000_0000, 8'b0, "drop0");

        // Owner 1 drops its request while 0 waits; then everything drops.
        applyStimulus(8'b0100_0000, 8'b0100_0000, "own1");
        applyStimulus(8'b1100_0000, 8'b0100_0000, "own1b");
        applyStimulus(8'b1000_0000, 8'b1000_0000, "handoff0");
        checkBits("handoff0.gnt", gnt, 8'b1000_0000);
        applyStimulus(8'b0000_0000, 8'b1000_0000, "alldrop");
        applyStimulus(8'b0000_0000, 8'b0111_1111, "idlehold");
        checkBits("idlehold.sel", {5'b0, j0, j1, j2}, 8'b0000_0000);

        // Full contention: each requester gets BURST cycles in ptr order.
        for (int c = 0; c < 9 * BURST; c++)
            applyStimulus(8'hFF, 8'($urandom), "all8");

        applyStimulus(8'b0000_0000, 8'b0, "drop8");
        applyStimulus(8'b0001_0000, 8'b0001_0000, "own3");
        applyStimulus(8'b0001_0000, 8'b0001_0000, "own3b");

        // Asynchronous reset mid-burst clears the grant before any clock edge.
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncrst");
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(8'b0001_0010, 8'b0001_0000, "post3_6");
        checkBits("post3_6.gnt", gnt, 8'b0001_0000);

        // Random phase: sticky requests that toggle occasionally, fresh data every cycle.
        rr = '0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            ri = 8'($urandom);
            applyStimulus(rr, ri, "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
